eth_axi_lite_regs: RTL
======================

Name: eth_axi_lite_regs

Overview:
AXI-Lite slave register block for the Ethernet MAC. It terminates the CPU-side AXI-Lite bus and exposes control and status registers to the MAC datapath: enables, MAC address, TX length, interrupt status/mask and frame counters. It sits directly downstream of the AXI-Lite bus and upstream of the MAC TX/RX engines.

Parameters:
AXI_ADDR_WIDTH, 32, address width; decode uses addr[7:2], all other bits ignored.
AXI_DATA_WIDTH, 32, data width; only 32 is supported (elaboration error otherwise).

Ports:
aclk  in  1  clock
aresetn  in  1  reset; one clock; reset is asynchronous and active-low
awaddr  in  AXI_ADDR_WIDTH  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  AXI_DATA_WIDTH  write data
wlast  in  1  ignored; single-beat only
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  00 OKAY, 10 SLVERR
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  AXI_ADDR_WIDTH  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  AXI_DATA_WIDTH  read data
rlast  out  1  equals rvalid
rvalid  out  1  read data valid
rready  in  1  read data ready
link_up  in  1  PHY link status
tx_busy  in  1  TX engine busy
rx_frame_done  in  1  one-cycle pulse per good RX frame
tx_frame_done  in  1  one-cycle pulse per sent frame
rx_crc_err  in  1  one-cycle pulse per bad-CRC frame
ctrl_tx_en  out  1  CTRL[0]
ctrl_rx_en  out  1  CTRL[1]
ctrl_tx_start  out  1  one-cycle pulse
ctrl_promisc  out  1  CTRL[3]
mac_addr  out  48  {MAC_HI[15:0], MAC_LO}
tx_len  out  16  TX_LEN[15:0]
irq  out  1  registered interrupt

Behaviour:
- Reset: awready, wready and arready are 1. bvalid, rvalid, rlast, bresp, rdata and ctrl_tx_start are 0. All registers are 0 except TX_LEN = 0x0040. irq is 0.
- Register map by offset:
  - 0x00 CTRL RW: [0] tx_en, [1] rx_en, [2] tx_start (write 1 pulses ctrl_tx_start for 1 cycle; always reads 0), [3] promisc.
  - 0x04 STATUS RO: [0] link_up, [1] tx_busy.
  - 0x08 MAC_LO RW [31:0]; 0x0C MAC_HI RW [15:0], upper bits read 0.
  - 0x10 TX_LEN RW [15:0].
  - 0x14 IRQ_STAT W1C: [0] rx_done, [1] tx_done, [2] crc_err.
  - 0x18 IRQ_MASK RW [2:0].
  - 0x1C RX_CNT, 0x20 TX_CNT, 0x24 ERR_CNT: 32-bit, saturate at 0xFFFFFFFF; any write clears to 0.
  - Offsets >= 0x28 are unmapped.
- Write FSM states WR_IDLE and WR_RESP:
  - In WR_IDLE, awready = ~aw_held and wready = ~w_held.
  - AW and W are captured independently, in either order.
  - When both are held, the register update occurs on that edge, the FSM moves to WR_RESP and bvalid = 1.
  - bresp = 10 for unmapped or RO targets (no register change), 00 otherwise.
  - bvalid and bresp hold until bready; the FSM then returns to WR_IDLE.
  - awready and wready stay 0 throughout WR_RESP.
- Write latency: if AW and W handshake in cycle N, bvalid is 1 in cycle N+1.
- Read FSM states RD_IDLE and RD_DATA:
  - In RD_IDLE, arready = 1.
  - On handshake in cycle N, rdata is registered and rvalid = rlast = 1 in cycle N+1.
  - rdata is stable until rready, then the FSM returns to RD_IDLE.
  - Unmapped reads return 0.
- Read and write channels are independent. A read whose AR handshake lands on the same edge as a write commit returns the pre-write value.
- IRQ_STAT:
  - Bits are set by the input pulses.
  - A hardware set and a W1C to the same bit in the same cycle: set wins.
- Counters: a hardware increment and a clear-write in the same cycle result in 0.
- irq = registered OR of (IRQ_STAT & IRQ_MASK), so it is asserted 1 cycle after the causing condition.
- Reset asserted mid-transaction: the FSMs return to IDLE immediately and any in-flight response is dropped.

Decomposition:
- Package eth_regs_pkg holds:
  - offset localparams (REG_CTRL … REG_ERR_CNT);
  - CTRL bit indices;
  - IRQ bit indices;
  - TX_LEN_RST = 16'h0040;
  - BRESP_OKAY = 2'b00 and BRESP_SLVERR = 2'b10.
- Sub-module eth_sat_counter (32-bit, inc pulse, clear, saturation) is instantiated 3 times.

Test Plan:
1. Write MAC_LO = 0xAABBCCDD with AW and W in the same cycle -> bvalid next cycle, bresp = 00, mac_addr[31:0] = 0xAABBCCDD; read back returns 0xAABBCCDD, rvalid one cycle after AR.
2. W presented 3 cycles before AW, with bready held low for 4 cycles -> single write commits, bvalid held for 4 cycles, awready and wready stay 0 until bready.
3. Write CTRL = 0x5 -> ctrl_tx_en = 1 and ctrl_tx_start high for exactly 1 cycle; CTRL reads 0x1.
4. IRQ_MASK = 0x1, then pulse rx_frame_done -> IRQ_STAT = 0x1, RX_CNT = 1, irq = 1. Write 0x1 to IRQ_STAT in the same cycle as a new rx_frame_done pulse -> bit stays 1 (set wins).
5. Write to 0x30 and to 0x04 -> bresp = 10 and no state change; read of 0x30 returns 0.
6. Reset asserted while in RD_DATA with rready low -> rvalid = 0 immediately; TX_LEN reads 0x0040 after reset.

Source files
------------

// File: rtl/eth_regs_pkg.sv
// Shared definitions for the Ethernet MAC AXI-Lite register block:
// register offsets, bit indices, reset values, FSM states, address decode.
package eth_regs_pkg;

  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_STATUS   = 8'h04;
  localparam logic [7:0] REG_MAC_LO   = 8'h08;
  localparam logic [7:0] REG_MAC_HI   = 8'h0C;
  localparam logic [7:0] REG_TX_LEN   = 8'h10;
  localparam logic [7:0] REG_IRQ_STAT = 8'h14;
  localparam logic [7:0] REG_IRQ_MASK = 8'h18;
  localparam logic [7:0] REG_RX_CNT   = 8'h1C;
  localparam logic [7:0] REG_TX_CNT   = 8'h20;
  localparam logic [7:0] REG_ERR_CNT  = 8'h24;

  localparam int CTRL_TX_EN    = 0;
  localparam int CTRL_RX_EN    = 1;
  localparam int CTRL_TX_START = 2;
  localparam int CTRL_PROMISC  = 3;

  localparam int IRQ_RX_DONE = 0;
  localparam int IRQ_TX_DONE = 1;
  localparam int IRQ_CRC_ERR = 2;

  localparam logic [15:0] TX_LEN_RST = 16'h0040;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_e;

  typedef struct packed {
    logic ctrl;
    logic status;
    logic mac_lo;
    logic mac_hi;
    logic tx_len;
    logic irq_stat;
    logic irq_mask;
    logic rx_cnt;
    logic tx_cnt;
    logic err_cnt;
  } reg_sel_t;

  // One-hot select from a word index; all zero means unmapped.
  function automatic reg_sel_t reg_decode(
    input logic [5:0] idx
  );
    reg_sel_t s;
    s = '0;
    unique case (idx)
      REG_CTRL[7:2]:     s.ctrl     = 1'b1;
      REG_STATUS[7:2]:   s.status   = 1'b1;
      REG_MAC_LO[7:2]:   s.mac_lo   = 1'b1;
      REG_MAC_HI[7:2]:   s.mac_hi   = 1'b1;
      REG_TX_LEN[7:2]:   s.tx_len   = 1'b1;
      REG_IRQ_STAT[7:2]: s.irq_stat = 1'b1;
      REG_IRQ_MASK[7:2]: s.irq_mask = 1'b1;
      REG_RX_CNT[7:2]:   s.rx_cnt   = 1'b1;
      REG_TX_CNT[7:2]:   s.tx_cnt   = 1'b1;
      REG_ERR_CNT[7:2]:  s.err_cnt  = 1'b1;
      default:           s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/eth_sat_counter.sv
// 32-bit saturating event counter: inc pulse, clear wins over inc.
// Ports: clk, rst_n, inc, clr -> cnt[31:0].
module eth_sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  output logic [31:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/eth_axi_lite_regs.sv
// AXI-Lite slave CSR block for the Ethernet MAC (ctrl, MAC addr, irq, counters).
// Ports: AXI-Lite AW/W/B/AR/R, MAC status inputs, ctrl/mac_addr/tx_len/irq outputs.
module eth_axi_lite_regs
  import eth_regs_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [AXI_DATA_WIDTH-1:0] wdata,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [AXI_ADDR_WIDTH-1:0] araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [AXI_DATA_WIDTH-1:0] rdata,
  output logic                      rlast,
  output logic                      rvalid,
  input  logic                      rready,
  input  logic                      link_up,
  input  logic                      tx_busy,
  input  logic                      rx_frame_done,
  input  logic                      tx_frame_done,
  input  logic                      rx_crc_err,
  output logic                      ctrl_tx_en,
  output logic                      ctrl_rx_en,
  output logic                      ctrl_tx_start,
  output logic                      ctrl_promisc,
  output logic [47:0]               mac_addr,
  output logic [15:0]               tx_len,
  output logic                      irq
);

  if (AXI_DATA_WIDTH != 32) begin : g_dw_check
    $error("eth_axi_lite_regs: AXI_DATA_WIDTH must be 32");
  end

  logic unused;
  assign unused = ^{wlast, awaddr, araddr};

  wr_state_e wr_q, wr_d;
  rd_state_e rd_q, rd_d;

  logic        aw_held, w_held;
  logic [5:0]  aw_idx_q;
  logic [31:0] w_data_q;
  logic        aw_fire, w_fire, wr_commit;
  logic [5:0]  wr_idx;
  logic [31:0] wr_dat;
  reg_sel_t    wr_sel, we;
  logic        wr_err;
  logic [1:0]  bresp_q;

  logic        ar_fire;
  reg_sel_t    rd_sel;
  logic [31:0] rd_mux;
  logic [31:0] rdata_q;

  logic [31:0] mac_lo;
  logic [15:0] mac_hi;
  logic [2:0]  irq_stat, irq_mask, irq_set, irq_clr;
  logic [31:0] rx_cnt, tx_cnt, err_cnt;

  // Write channel
  assign awready = (wr_q == WR_IDLE) & ~aw_held;
  assign wready  = (wr_q == WR_IDLE) & ~w_held;
  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;

  assign wr_commit = (wr_q == WR_IDLE)
                   & (aw_held | aw_fire)
                   & (w_held | w_fire);

  // Use the live bus value when that half arrives on the commit edge.
  assign wr_idx = aw_held ? aw_idx_q : awaddr[7:2];
  assign wr_dat = w_held ? w_data_q : wdata;

  assign wr_sel = reg_decode(wr_idx);
  assign wr_err = (wr_sel == '0) | wr_sel.status;
  assign we     = (wr_commit && !wr_err) ? wr_sel : '0;

  always_comb begin
    wr_d = wr_q;
    unique case (wr_q)
      WR_IDLE: if (wr_commit) wr_d = WR_RESP;
      WR_RESP: if (bready)    wr_d = WR_IDLE;
      default: wr_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_q     <= WR_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      bresp_q  <= BRESP_OKAY;
    end else begin
      wr_q <= wr_d;
      if (aw_fire) aw_idx_q <= awaddr[7:2];
      if (w_fire)  w_data_q <= wdata;
      if (wr_commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp_q <= wr_err ? BRESP_SLVERR : BRESP_OKAY;
      end else begin
        if (aw_fire) aw_held <= 1'b1;
        if (w_fire)  w_held  <= 1'b1;
      end
    end
  end

  assign bvalid = (wr_q == WR_RESP);
  assign bresp  = bresp_q;

  // Register file
  assign irq_set = {rx_crc_err, tx_frame_done, rx_frame_done};
  assign irq_clr = we.irq_stat ? wr_dat[2:0] : 3'b000;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl_tx_en    <= 1'b0;
      ctrl_rx_en    <= 1'b0;
      ctrl_promisc  <= 1'b0;
      ctrl_tx_start <= 1'b0;
      mac_lo        <= '0;
      mac_hi        <= '0;
      tx_len        <= TX_LEN_RST;
      irq_stat      <= '0;
      irq_mask      <= '0;
      irq           <= 1'b0;
    end else begin
      ctrl_tx_start <= we.ctrl & wr_dat[CTRL_TX_START];
      if (we.ctrl) begin
        ctrl_tx_en   <= wr_dat[CTRL_TX_EN];
        ctrl_rx_en   <= wr_dat[CTRL_RX_EN];
        ctrl_promisc <= wr_dat[CTRL_PROMISC];
      end
      if (we.mac_lo)   mac_lo   <= wr_dat;
      if (we.mac_hi)   mac_hi   <= wr_dat[15:0];
      if (we.tx_len)   tx_len   <= wr_dat[15:0];
      if (we.irq_mask) irq_mask <= wr_dat[2:0];
      // Set after clear: a pulse coincident with W1C survives.
      irq_stat <= (irq_stat & ~irq_clr) | irq_set;
      irq      <= |(irq_stat & irq_mask);
    end
  end

  assign mac_addr = {mac_hi, mac_lo};

  eth_sat_counter u_rx_cnt (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (rx_frame_done),
    .clr   (we.rx_cnt),
    .cnt   (rx_cnt)
  );

  eth_sat_counter u_tx_cnt (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (tx_frame_done),
    .clr   (we.tx_cnt),
    .cnt   (tx_cnt)
  );

  eth_sat_counter u_err_cnt (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (rx_crc_err),
    .clr   (we.err_cnt),
    .cnt   (err_cnt)
  );

  // Read channel
  assign arready = (rd_q == RD_IDLE);
  assign ar_fire = arvalid & arready;
  assign rd_sel  = reg_decode(araddr[7:2]);

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      rd_sel.ctrl:
        rd_mux = {28'd0, ctrl_promisc, 1'b0,
                  ctrl_rx_en, ctrl_tx_en};
      rd_sel.status:   rd_mux = {30'd0, tx_busy, link_up};
      rd_sel.mac_lo:   rd_mux = mac_lo;
      rd_sel.mac_hi:   rd_mux = {16'd0, mac_hi};
      rd_sel.tx_len:   rd_mux = {16'd0, tx_len};
      rd_sel.irq_stat: rd_mux = {29'd0, irq_stat};
      rd_sel.irq_mask: rd_mux = {29'd0, irq_mask};
      rd_sel.rx_cnt:   rd_mux = rx_cnt;
      rd_sel.tx_cnt:   rd_mux = tx_cnt;
      rd_sel.err_cnt:  rd_mux = err_cnt;
      default:         rd_mux = '0;
    endcase
  end

  always_comb begin
    rd_d = rd_q;
    unique case (rd_q)
      RD_IDLE: if (ar_fire) rd_d = RD_DATA;
      RD_DATA: if (rready)  rd_d = RD_IDLE;
      default: rd_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_q    <= RD_IDLE;
      rdata_q <= '0;
    end else begin
      rd_q <= rd_d;
      if (ar_fire) rdata_q <= rd_mux;
    end
  end

  assign rvalid = (rd_q == RD_DATA);
  assign rlast  = rvalid;
  assign rdata  = rdata_q;

endmodule
